// File: rtl/hdmi_text_render.sv
// Text-mode overlay for a video timing stream: fetches character cells and glyph rows,
// then emits palette colours with the timing signals delayed to match (4 clocks).
module hdmi_text_render #(
  parameter int COLS         = 100,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 10,
  parameter int CHAR_H       = 24,
  parameter int BLINK_FRAMES = 32,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int HW = $clog2(CHAR_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_active,
  input  logic              in_h_sync,
  input  logic              in_v_sync,
  input  logic              in_h_start,
  input  logic              in_v_start,
  input  logic [RW-1:0]     top_row,
  input  logic              cursor_en,
  input  logic [RW-1:0]     cursor_row,
  input  logic [CW-1:0]     cursor_col,
  output logic              vram_ce,
  output logic [RW-1:0]     vram_row,
  output logic [CW-1:0]     vram_col,
  input  logic [15:0]       vram_data,
  output logic              rom_ce,
  output logic [7:0]        rom_char,
  output logic [HW-1:0]     rom_row,
  input  logic [CHAR_W-1:0] rom_q,
  output logic              out_active,
  output logic              out_h_sync,
  output logic              out_v_sync,
  output logic [23:0]       out_rgb
);
  localparam int PXW = $clog2(CHAR_W);
  localparam int CCW = $clog2(COLS + 1);
  localparam int SRW = $clog2(ROWS + 1);
  localparam int BW  = $clog2(BLINK_FRAMES + 1);
  localparam logic [PXW-1:0] PX_LAST    = PXW'(CHAR_W - 1);
  localparam logic [HW-1:0]  LN_LAST    = HW'(CHAR_H - 1);
  localparam logic [CCW-1:0] COLS_C     = CCW'(COLS);
  localparam logic [SRW-1:0] ROWS_S     = SRW'(ROWS);
  localparam logic [RW:0]    ROWS_R     = (RW + 1)'(ROWS);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PXW-1:0] px_reg, px_cur;
  logic [CCW-1:0] col_reg, col_cur;
  logic [HW-1:0]  ln_reg, ln_cur;
  logic [SRW-1:0] srow_reg, srow_cur;
  logic           frame_ok_reg, frame_ok_cur;
  logic [BW-1:0]  blink_cnt_reg;
  logic           blink_reg;
  logic           visible, cursor_hit;
  logic [RW:0]    row_sum;

  logic [2:0]        sync_d [4];
  logic              s1_vis, s1_first, s1_cur;
  logic [HW-1:0]     s1_ln;
  logic              s2_vis, s2_first, s2_cur;
  logic              s3_vis, s3_first, s3_cur;
  logic [7:0]        attr_reg;
  logic [CHAR_W-1:0] shift_reg, glyph;
  logic              pix_on, swap;
  logic [23:0]       rgb_next;

  function automatic logic [7:0] chan(input logic on, input logic hi);
    case ({on, hi})
      2'b11:   chan = 8'hFF;
      2'b10:   chan = 8'hAA;
      2'b01:   chan = 8'h55;
      default: chan = 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] pal(input logic [3:0] c);
    pal = {chan(c[2], c[3]), chan(c[1], c[3]), chan(c[0], c[3])};
  endfunction

  // Coordinates of the pixel presented this cycle (start strobes take effect immediately)
  always_comb begin
    px_cur   = in_h_start ? '0 : px_reg;
    col_cur  = in_h_start ? '0 : col_reg;
    ln_cur   = ln_reg;
    srow_cur = srow_reg;
    if (in_v_start) begin
      ln_cur   = '0;
      srow_cur = '0;
    end else if (in_h_start) begin
      if (ln_reg == LN_LAST) begin
        ln_cur = '0;
        if (srow_reg != ROWS_S) srow_cur = srow_reg + 1'b1;
      end else begin
        ln_cur = ln_reg + 1'b1;
      end
    end
    frame_ok_cur = frame_ok_reg | in_v_start;
    visible      = in_active && frame_ok_cur && (col_cur < COLS_C) && (srow_cur < ROWS_S);
    row_sum      = {1'b0, srow_cur[RW-1:0]} + {1'b0, top_row};
    cursor_hit   = cursor_en && (srow_cur == SRW'(cursor_row)) && (col_cur == CCW'(cursor_col));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_reg        <= '0;
      col_reg       <= '0;
      ln_reg        <= '0;
      srow_reg      <= '0;
      frame_ok_reg  <= 1'b0;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else begin
      ln_reg       <= ln_cur;
      srow_reg     <= srow_cur;
      frame_ok_reg <= frame_ok_cur;
      px_reg       <= px_cur;
      col_reg      <= col_cur;
      if (in_active) begin
        if (px_cur == PX_LAST) begin
          px_reg <= '0;
          if (col_cur != COLS_C) col_reg <= col_cur + 1'b1;
        end else begin
          px_reg <= px_cur + 1'b1;
        end
      end
      // The v_start that arms output after reset is frame 0 and is not counted
      if (in_v_start && frame_ok_reg) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg <= '0;
          blink_reg     <= ~blink_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rom_char = rom_ce ? vram_data[7:0] : '0;

  always_comb begin
    glyph    = s3_first ? rom_q : shift_reg;
    pix_on   = glyph[CHAR_W-1] && !(attr_reg[7] && blink_reg);
    swap     = s3_cur && !blink_reg;
    rgb_next = (pix_on ^ swap) ? pal(attr_reg[3:0]) : pal({1'b0, attr_reg[6:4]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) sync_d[i] <= '0;
      vram_ce   <= 1'b0;
      vram_row  <= '0;
      vram_col  <= '0;
      rom_ce    <= 1'b0;
      rom_row   <= '0;
      s1_vis    <= 1'b0;
      s1_first  <= 1'b0;
      s1_cur    <= 1'b0;
      s1_ln     <= '0;
      s2_vis    <= 1'b0;
      s2_first  <= 1'b0;
      s2_cur    <= 1'b0;
      s3_vis    <= 1'b0;
      s3_first  <= 1'b0;
      s3_cur    <= 1'b0;
      attr_reg  <= '0;
      shift_reg <= '0;
      out_rgb   <= '0;
    end else begin
      sync_d[0] <= {in_active, in_h_sync, in_v_sync};
      for (int i = 1; i < 4; i++) sync_d[i] <= sync_d[i-1];
      vram_ce <= visible && (px_cur == '0);
      if (visible && (px_cur == '0)) begin
        vram_row <= RW'((row_sum >= ROWS_R) ? row_sum - ROWS_R : row_sum);
        vram_col <= col_cur[CW-1:0];
      end
      s1_vis   <= visible;
      s1_first <= (px_cur == '0);
      s1_cur   <= cursor_hit;
      s1_ln    <= ln_cur;
      rom_ce   <= vram_ce;
      rom_row  <= s1_ln;
      s2_vis   <= s1_vis;
      s2_first <= s1_first;
      s2_cur   <= s1_cur;
      if (rom_ce) attr_reg <= vram_data[15:8];
      s3_vis   <= s2_vis;
      s3_first <= s2_first;
      s3_cur   <= s2_cur;
      shift_reg <= glyph << 1;
      out_rgb   <= s3_vis ? rgb_next : '0;
    end
  end

  assign {out_active, out_h_sync, out_v_sync} = sync_d[3];
endmodule
